// File: rtl/dcmi_pkg.sv
// Shared definitions for the DCMI DMA controller: default widths and the
// controller state encoding.
package dcmi_pkg;

    localparam int DCMI_AW = 18;
    localparam int DCMI_DW = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } dma_state_e;

endpackage

// File: rtl/dcmi_dma_addr_gen.sv
// Circular write-address generator for the DCMI DMA controller.
// Holds the window start/length captured at load time, the current word
// address and the in-window word count. A window length of 0 means the full
// 2^AW space: the address simply rolls over and the wrap strobe marks the
// all-ones to zero transition.
module dcmi_dma_addr_gen
    import dcmi_pkg::*;
#(
    parameter int AW = DCMI_AW
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          i_load,
    input  logic [AW-1:0] i_saddr,
    input  logic [AW-1:0] i_len,
    input  logic          i_inc,
    output logic [AW-1:0] o_addr,
    output logic          o_wrap
);

    logic [AW-1:0] r_addr;
    logic [AW-1:0] r_wcnt;
    logic [AW-1:0] r_saddr;
    logic [AW-1:0] r_len;
    logic          r_wrap;
    logic          w_last;
    logic          w_roll;

    // last word of a finite window, or rollover of a full-space window
    always_comb begin
        w_last = (r_len != '0) && (r_wcnt == (r_len - AW'(1)));
        w_roll = (r_len == '0) && (r_addr == '1);
    end

    // window capture, address advance and single-cycle wrap strobe
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_addr  <= '0;
            r_wcnt  <= '0;
            r_saddr <= '0;
            r_len   <= '0;
            r_wrap  <= 1'b0;
        end else begin
            r_wrap <= 1'b0;
            if (i_load) begin
                r_addr  <= i_saddr;
                r_saddr <= i_saddr;
                r_len   <= i_len;
                r_wcnt  <= '0;
            end else if (i_inc) begin
                if (w_last) begin
                    r_addr <= r_saddr;
                    r_wcnt <= '0;
                    r_wrap <= 1'b1;
                end else begin
                    r_addr <= r_addr + AW'(1);
                    r_wcnt <= r_wcnt + AW'(1);
                    r_wrap <= w_roll;
                end
            end
        end
    end

    assign o_addr = r_addr;
    assign o_wrap = r_wrap;

endmodule

// File: rtl/dcmi_dma_ctrl.sv
// DCMI DMA controller: moves captured words from the ping-pong buffer head
// into word-addressed SRAM over a req/gnt port, walking a circular window.
// Optional feature macro: DCMI_DMA_WCNT_EN adds the frame_wcnt output
// (words written in the last completed frame).
module dcmi_dma_ctrl
    import dcmi_pkg::*;
#(
    parameter int AW = DCMI_AW,
    parameter int DW = DCMI_DW
) (
    input  logic          hclk,
    input  logic          rstn,
    input  logic          capture_en,
    input  logic          capture_start,
    input  logic          snapshot_mode,
    input  logic          frame_end,
    input  logic [AW-1:0] dma_saddr,
    input  logic [AW-1:0] dma_len,
    input  logic          buf_rdy,
    input  logic [DW-1:0] buf_data,
    output logic          buf_rd,
    output logic          mem_req,
    input  logic          mem_gnt,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          dma_busy,
    output logic          dma_frame_done,
    output logic          dma_wrap
`ifdef DCMI_DMA_WCNT_EN
    ,
    output logic [AW-1:0] frame_wcnt
`endif
);

    dma_state_e    r_state;
    dma_state_e    w_nstate;
    logic          r_busy;
    logic          r_end_pend;
    logic [DW-1:0] r_wdata;
    logic          w_load;
    logic          w_pop;
    logic          w_inc;

    // state register, busy flag, pending frame end and write data latch
    always_ff @(posedge hclk) begin
        if (!rstn) begin
            r_state    <= IDLE;
            r_busy     <= 1'b0;
            r_end_pend <= 1'b0;
            r_wdata    <= '0;
        end else begin
            r_state <= w_nstate;
            r_busy  <= (w_nstate != IDLE);
            if (w_pop) begin
                r_wdata <= buf_data;
            end
            // a frame end arriving in DONE belongs to the next frame, so set wins
            if (w_load) begin
                r_end_pend <= 1'b0;
            end else if (frame_end && (r_state != IDLE)) begin
                r_end_pend <= 1'b1;
            end else if (r_state == DONE) begin
                r_end_pend <= 1'b0;
            end
        end
    end

    // next-state and strobe decode; abort has priority over fetching
    always_comb begin
        w_nstate = r_state;
        w_load   = 1'b0;
        w_pop    = 1'b0;
        case (r_state)
            IDLE: begin
                if (capture_start) begin
                    w_load   = 1'b1;
                    w_nstate = FETCH;
                end
            end
            FETCH: begin
                if (!capture_en) begin
                    w_nstate = IDLE;
                end else if (buf_rdy) begin
                    w_pop    = 1'b1;
                    w_nstate = WRITE;
                end else if (r_end_pend) begin
                    w_nstate = DONE;
                end
            end
            WRITE: begin
                if (mem_gnt) begin
                    w_nstate = FETCH;
                end
            end
            DONE: begin
                if (snapshot_mode || !capture_en) begin
                    w_nstate = IDLE;
                end else begin
                    w_nstate = FETCH;
                end
            end
            default: w_nstate = IDLE;
        endcase
    end

    assign w_inc = (r_state == WRITE) && mem_gnt;

    dcmi_dma_addr_gen #(
        .AW (AW)
    ) u_addr_gen (
        .clk     (hclk),
        .rstn    (rstn),
        .i_load  (w_load),
        .i_saddr (dma_saddr),
        .i_len   (dma_len),
        .i_inc   (w_inc),
        .o_addr  (mem_addr),
        .o_wrap  (dma_wrap)
    );

`ifdef DCMI_DMA_WCNT_EN
    logic [AW-1:0] r_fcnt;
    logic [AW-1:0] r_frame_wcnt;

    // per-frame write count, published on entry to DONE
    always_ff @(posedge hclk) begin
        if (!rstn) begin
            r_fcnt       <= '0;
            r_frame_wcnt <= '0;
        end else begin
            if (w_load || (r_state == DONE)) begin
                r_fcnt <= '0;
            end else if (w_inc) begin
                r_fcnt <= r_fcnt + AW'(1);
            end
            if ((r_state != DONE) && (w_nstate == DONE)) begin
                r_frame_wcnt <= r_fcnt;
            end
        end
    end

    assign frame_wcnt = r_frame_wcnt;
`endif

    assign buf_rd         = w_pop;
    assign mem_req        = (r_state == WRITE);
    assign mem_wdata      = r_wdata;
    assign dma_busy       = r_busy;
    assign dma_frame_done = (r_state == DONE);

endmodule

// File: doc/dcmi_dma_ctrl.md
Name: dcmi_dma_ctrl

Overview:
- Sequences DMA transfers of captured DCMI words from the ping-pong buffer output into a word-addressed on-chip SRAM.
- Programmed by the DCMI register block through dma_saddr, dma_len, capture_en, capture_start and snapshot_mode.
- Walks a circular address window, arbitrates for the memory port with a req/gnt handshake, and raises frame and wrap events for the IRQ logic.

Parameters:
- AW, 18, memory word-address width; equals width of dma_saddr and dma_len.
- DW, 32, data word width.

Ports:
- hclk  in  1  system clock; all logic on posedge.
- rstn  in  1  reset; synchronous, active-low.
- capture_en  in  1  capture enable from the register block.
- capture_start  in  1  one-cycle pulse: capture is being enabled.
- snapshot_mode  in  1  1: single frame; 0: continuous.
- frame_end  in  1  one-cycle pulse: last word of the frame is already in the buffer.
- dma_saddr  in  AW  window start word address.
- dma_len  in  AW  window length in words; 0 means 2^AW.
- buf_rdy  in  1  buffer holds at least one word.
- buf_data  in  DW  head word; valid while buf_rdy.
- buf_rd  out  1  pop pulse; head is consumed on the same edge.
- mem_req  out  1  write request.
- mem_gnt  in  1  grant; a write completes on the edge where mem_req&mem_gnt.
- mem_addr  out  AW  write address.
- mem_wdata  out  DW  write data.
- dma_busy  out  1  controller not IDLE.
- dma_frame_done  out  1  one-cycle pulse: frame fully written.
- dma_wrap  out  1  one-cycle pulse: address wrapped to dma_saddr.

Behaviour:
- Reset: state=IDLE; mem_req=0; mem_addr=0; mem_wdata=0; buf_rd=0; dma_busy=0; dma_frame_done=0; dma_wrap=0; internal word counter wcnt=0; end_pend=0.
- State IDLE:
  - capture_start=1 → load mem_addr=dma_saddr, wcnt=0, end_pend=0; go to FETCH.
  - dma_saddr and dma_len are sampled only here; later register writes do not affect an active capture.
- State FETCH:
  - buf_rdy=1 → buf_rd=1 for exactly one cycle, mem_wdata<=buf_data; go to WRITE.
  - buf_rdy=0 and end_pend=1 → go to DONE.
  - capture_en=0 → go to IDLE (abort, no done pulse).
- State WRITE:
  - mem_req=1; mem_addr and mem_wdata held stable until grant.
  - On grant: mem_req deasserts next cycle; wcnt+1; mem_addr+1.
  - If the granted write was word dma_len-1 of the window: mem_addr<=dma_saddr, wcnt<=0, dma_wrap pulse.
  - Then go to FETCH.
  - The first write is issued at the earliest 2 cycles after capture_start (FETCH, then WRITE).
  - Steady-state throughput is 1 word per 2 cycles with mem_gnt tied high.
- frame_end handling:
  - frame_end in any non-IDLE state sets end_pend.
  - DONE is entered only from FETCH with the buffer drained, so no word is lost.
  - frame_end in IDLE is ignored.
- State DONE (1 cycle): dma_frame_done=1; end_pend<=0.
  - snapshot_mode=1 or capture_en=0 → IDLE.
  - Otherwise → FETCH; mem_addr continues without reload, so consecutive frames pack contiguously.
- capture_en falling while in WRITE: the current write still completes on grant, then the next FETCH goes to IDLE. There is no partial write.
- capture_start while busy: ignored.
- Address arithmetic: modulo 2^AW. dma_len=0 wraps only at the 2^AW-word boundary, and dma_wrap still pulses.
- dma_busy = (state != IDLE), registered.
- Simultaneous events:
  - Grant and frame_end in the same cycle: both take effect (count advances, end_pend set).
  - Wrap and frame done never coincide (different states).
- Synchronous reset mid-transfer returns to IDLE next edge and drops mem_req immediately at that edge.

Optional Feature:
- DCMI_DMA_WCNT_EN defined:
  - Adds output frame_wcnt[AW-1:0], reset 0.
  - Loaded with the number of words written in the frame (mod 2^AW, not reset on wrap) in the DONE cycle.
  - The frame counter clears on leaving DONE.
- Undefined: port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Shared package dcmi_pkg: state encoding enum (IDLE, FETCH, WRITE, DONE) and the AW/DW defaults.
- One natural sub-module, dcmi_dma_addr_gen: address/wcnt register with load, increment and wrap-compare, outputting mem_addr and the wrap strobe.
- The FSM stays in dcmi_dma_ctrl.

Test Plan:
- Wrap: saddr=0x100, len=4, snapshot=1, gnt tied 1, 6 words then frame_end → addresses 100,101,102,103,100,101; dma_wrap once after the 4th grant; dma_frame_done once; back to IDLE.
- Grant backpressure: mem_gnt low 5 cycles → mem_req, mem_addr and mem_wdata held stable; exactly one buf_rd per word; no data loss or duplication.
- Continuous mode: snapshot=0, 3-word frames ×2 at saddr=0x10, len=0 → addresses 0x10–0x15; two frame_done pulses; dma_busy stays 1.
- Abort: clear capture_en during WRITE with gnt delayed → the pending write completes, then IDLE with no done pulse; a later capture_start restarts at the current dma_saddr.
- Boundary: saddr=0x3FFFF, len=0 → second word goes to address 0x00000 with dma_wrap pulsed.
- Reset: assert rstn=0 for one edge mid-WRITE → all outputs 0 next cycle. With DCMI_DMA_WCNT_EN, frame_wcnt=5 after a 5-word frame.
